// File: rtl/phase_pkg.sv
// Shared dual-rail encodings and sequencer state type
// for the phase sequencing controller.
package phase_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT_LO,
        ERROR
    } state_e;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_D0   = 2'b01;
    localparam logic [1:0] DR_D1   = 2'b10;

    function automatic logic [1:0] dr_token(input logic parity);
        return parity ? DR_D1 : DR_D0;
    endfunction

endpackage

// File: rtl/ack_sync.sv
// Reset-to-zero multi-flop synchronizer for one
// asynchronous acknowledge line.
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/phase_seq_ctrl.sv
// Three-phase dual-rail token sequencer with four-phase
// ack handshakes, step mode and wait timeout.
module phase_seq_ctrl
    import phase_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             step_mode,
    input  logic             step,
    input  logic             clr_err,
    output logic [1:0]       PH0,
    output logic [1:0]       PH1,
    output logic [1:0]       PH2,
    input  logic             ack_PH0_1,
    input  logic             ack_PH0_2,
    input  logic             ack_PH0_3,
    input  logic             ack_PH1_1,
    input  logic             ack_PH2_1,
    output logic             busy,
    output logic [1:0]       cur_phase,
    output logic             timeout_err,
    output logic [CNT_W-1:0] round_cnt
);

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [4:0] ack_raw;
    logic [4:0] ack_s;

    assign ack_raw = {ack_PH2_1, ack_PH1_1, ack_PH0_3,
                      ack_PH0_2, ack_PH0_1};

    for (genvar g = 0; g < 5; g++) begin : g_sync
        ack_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (ack_raw[g]),
            .q_o   (ack_s[g])
        );
    end

    state_e           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] rnd_q, rnd_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [2:0][1:0]  ph_q, ph_d;
    logic             grp_hi, grp_lo, tmo;

    always_comb begin
        grp_hi = ack_s[4];
        grp_lo = ~ack_s[4];
        case (cur_q)
            2'd0: begin
                grp_hi = &ack_s[2:0];
                grp_lo = ~|ack_s[2:0];
            end
            2'd1: begin
                grp_hi = ack_s[3];
                grp_lo = ~ack_s[3];
            end
            default: ;
        endcase
    end

    assign tmo = (TIMEOUT != 0) && (wcnt_q == WCW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rnd_d   = rnd_q;
        wcnt_d  = wcnt_q + WCW'(1);
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (en && (!step_mode || step)) state_d = DRIVE;
            end
            DRIVE: begin
                if (grp_hi) begin
                    state_d = WAIT_LO;
                    wcnt_d  = '0;
                end else if (tmo) begin
                    state_d = ERROR;
                end
            end
            WAIT_LO: begin
                if (grp_lo) begin
                    wcnt_d = '0;
                    if (cur_q == 2'd2) begin
                        cur_d = 2'd0;
                        rnd_d = rnd_q + CNT_W'(1);
                    end else begin
                        cur_d = cur_q + 2'd1;
                    end
                    state_d = (en && !step_mode) ? DRIVE : IDLE;
                end else if (tmo) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                wcnt_d = '0;
                if (clr_err) begin
                    state_d = IDLE;
                    cur_d   = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next state so consumers see glitch-free rails
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ph_d[i] = DR_NULL;
            if (state_d == DRIVE && cur_d == 2'(i))
                ph_d[i] = dr_token(rnd_d[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rnd_q   <= '0;
            wcnt_q  <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rnd_q   <= rnd_d;
            wcnt_q  <= wcnt_d;
            ph_q    <= ph_d;
        end
    end

    assign PH0         = ph_q[0];
    assign PH1         = ph_q[1];
    assign PH2         = ph_q[2];
    assign busy        = (state_q == DRIVE) || (state_q == WAIT_LO);
    assign timeout_err = (state_q == ERROR);
    assign cur_phase   = cur_q;
    assign round_cnt   = rnd_q;

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed and randomized bench for phase_seq_ctrl against a
// token-sequence reference model.
module tb_phase_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, step_mode, step, clr_err;
    logic [4:0]  ackv;
    logic [1:0]  ph0, ph1, ph2;
    logic        busy, terr;
    logic [1:0]  cur;
    logic [15:0] rnd;

    int tests = 0;
    int fails = 0;
    int n_tok = 0;
    bit auto_ack = 1'b0;
    logic [1:0] prev_ph [3];
    int acnt [5];
    int adly [5];

    always #5 clk = ~clk;

    phase_seq_ctrl #(
        .SYNC_STAGES (2),
        .TIMEOUT     (16),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .step_mode   (step_mode),
        .step        (step),
        .clr_err     (clr_err),
        .PH0         (ph0),
        .PH1         (ph1),
        .PH2         (ph2),
        .ack_PH0_1   (ackv[0]),
        .ack_PH0_2   (ackv[1]),
        .ack_PH0_3   (ackv[2]),
        .ack_PH1_1   (ackv[3]),
        .ack_PH2_1   (ackv[4]),
        .busy        (busy),
        .cur_phase   (cur),
        .timeout_err (terr),
        .round_cnt   (rnd)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ph_of(int p);
        case (p)
            0:       return ph0;
            1:       return ph1;
            default: return ph2;
        endcase
    endfunction

    // Model: the n-th token since reset goes to phase n%3 and
    // carries 01 on even rounds, 10 on odd rounds.
    task automatic tick();
        int nn;
        logic [1:0] v;
        logic tgt;
        @(posedge clk);
        #1;
        nn = 0;
        for (int p = 0; p < 3; p++) begin
            v = ph_of(p);
            if (v != 2'b00) nn++;
            if (prev_ph[p] == 2'b00 && v != 2'b00) begin
                chk("tok_phase", p, n_tok % 3);
                chk("tok_value", v, ((n_tok / 3) % 2) ? 2 : 1);
                n_tok++;
            end else if (prev_ph[p] != 2'b00 && v != 2'b00) begin
                chk("tok_hold", v, prev_ph[p]);
            end
            prev_ph[p] = v;
        end
        chk("one_hot", nn <= 1, 1);
        if (nn != 0) chk("busy_tok", busy, 1);
        if (auto_ack) begin
            for (int i = 0; i < 5; i++) begin
                tgt = ph_of(i < 3 ? 0 : i - 2) != 2'b00;
                if (ackv[i] != tgt) begin
                    acnt[i]++;
                    if (acnt[i] >= adly[i]) begin
                        ackv[i] = tgt;
                        acnt[i] = 0;
                        adly[i] = $urandom_range(1, 4);
                    end
                end else begin
                    acnt[i] = 0;
                end
            end
        end
    endtask

    task automatic wait_idle(int bound);
        int k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        chk("idle_in_time", busy, 0);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    initial begin
        int p;
        bit found;
        rst_n = 1'b0; en = 1'b0; step_mode = 1'b0;
        step = 1'b0; clr_err = 1'b0; ackv = '0;
        for (int i = 0; i < 3; i++) prev_ph[i] = 2'b00;
        for (int i = 0; i < 5; i++) begin
            acnt[i] = 0;
            adly[i] = 1;
        end

        tick(); tick();
        chk("rst_ph0", ph0, 0);
        chk("rst_ph1", ph1, 0);
        chk("rst_ph2", ph2, 0);
        chk("rst_cur", cur, 0);
        chk("rst_rnd", rnd, 0);
        chk("rst_err", terr, 0);
        chk("rst_busy", busy, 0);
        n_tok = 0;
        rst_n = 1'b1;
        tick();

        // Partial PH0 ack holds the token
        en = 1'b1;
        tick();
        chk("p0_tok", ph0, 2'b01);
        ackv[1:0] = 2'b11;
        repeat (6) tick();
        chk("p0_partial_hold", ph0, 2'b01);
        chk("p0_partial_cur", cur, 0);
        ackv[2] = 1'b1;
        tick(); tick();
        chk("p0_ack3_2cyc", ph0, 2'b01);
        tick();
        chk("p0_ack3_3cyc", ph0, 2'b00);
        chk("p0_wait_busy", busy, 1);
        en = 1'b0;
        ackv = '0;
        repeat (3) tick();
        chk("p0_done_idle", busy, 0);
        chk("p0_done_cur", cur, 1);

        // en dropped while PH1 is driven
        en = 1'b1;
        auto_ack = 1'b1;
        tick();
        chk("en_ph1_tok", ph1, 2'b01);
        en = 1'b0;
        wait_idle(60);
        chk("en_drop_cur", cur, 2);
        chk("en_drop_ph1", ph1, 0);

        // Step mode
        en = 1'b1;
        step_mode = 1'b1;
        repeat (3) tick();
        chk("step_wait", busy, 0);
        pulse_step();
        chk("step_ph2", ph2, 2'b01);
        tick();
        pulse_step();
        wait_idle(60);
        chk("step1_cur", cur, 0);
        chk("step1_rnd", rnd, 1);
        repeat (3) tick();
        chk("step_ignored", busy, 0);
        pulse_step();
        wait_idle(60);
        chk("step2_cur", cur, 1);
        pulse_step();
        wait_idle(60);
        chk("step3_cur", cur, 2);

        // Randomized run with wandering en
        step_mode = 1'b0;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            step = ($urandom_range(0, 7) == 0);
            tick();
        end
        step = 1'b0;
        en = 1'b0;
        wait_idle(80);
        chk("rand_rnd", rnd, n_tok / 3);
        chk("rand_cur", cur, n_tok % 3);
        chk("rand_err", terr, 0);

        // Timeout with no acks
        auto_ack = 1'b0;
        repeat (4) tick();
        p = int'(cur);
        en = 1'b1;
        tick();
        chk("tmo_tok", ph_of(p) != 2'b00, 1);
        repeat (15) tick();
        chk("tmo_hold16", ph_of(p) != 2'b00, 1);
        chk("tmo_err_early", terr, 0);
        tick();
        chk("tmo_drop17", ph_of(p), 0);
        chk("tmo_err", terr, 1);
        chk("tmo_busy", busy, 0);
        en = 1'b0;
        repeat (3) tick();
        chk("tmo_sticky", terr, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", terr, 0);
        chk("clr_cur", cur, 0);
        chk("clr_busy", busy, 0);
        chk("clr_rnd_kept", rnd, (n_tok - 1) / 3);
        n_tok = ((n_tok - 1) / 3) * 3;

        // Reset in WAIT_LO of PH2 at round 5
        rst_n = 1'b0;
        n_tok = 0;
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        auto_ack = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            tick();
            if (rnd == 16'd5 && cur == 2'd2 && busy && ph2 == 2'b00)
                found = 1'b1;
        end
        chk("r5_reached", found, 1);
        rst_n = 1'b0;
        n_tok = 0;
        tick();
        chk("r5_rst_ph0", ph0, 0);
        chk("r5_rst_ph1", ph1, 0);
        chk("r5_rst_ph2", ph2, 0);
        chk("r5_rst_cur", cur, 0);
        chk("r5_rst_rnd", rnd, 0);
        chk("r5_rst_busy", busy, 0);
        chk("r5_rst_err", terr, 0);
        rst_n = 1'b1;
        en = 1'b0;
        repeat (8) tick();
        chk("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
